// File: rtl/shift_register_universal.sv
// ---------------------------------------------------------------------------
// shift_register_universal
//
// Universal shift register built on the 74LS164 serial-in/parallel-out idea:
// hold, shift right (toward the MSB), shift left (toward the LSB), parallel
// load, clock enable and a frame counter that reports how many bits have been
// shifted in since the last load or reset.
//
// Optional feature macro: SHIFT_REG_ROTATE_EN
//   Defined   -> ROT=1 turns a shift into a rotate (the bit leaving one end
//                re-enters at the other end instead of the serial input).
//   Undefined -> ROT is kept as a pin but has no effect.
//
// Ports
//   CP        clock, rising edge
//   MR        synchronous active-high master reset (overrides everything)
//   CE        clock enable; low holds all state
//   S[1:0]    mode: 00 hold, 01 shift right, 10 shift left, 11 load
//   DSA, DSB  gated right-shift serial data (effective bit DSA & DSB)
//   DSL       left-shift serial data
//   ROT       rotate request (only with SHIFT_REG_ROTATE_EN)
//   D         parallel load data
//   Q         register contents
//   SOR       right-shift serial out, Q[WIDTH-1]
//   SOL       left-shift serial out, Q[0]
//   CNT       bits shifted since last load/reset, 0..WIDTH
//   FULL      registered flag, high exactly when CNT == WIDTH
// ---------------------------------------------------------------------------
module shift_register_universal #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             CP,
    input  logic             MR,
    input  logic             CE,
    input  logic [1:0]       S,
    input  logic             DSA,
    input  logic             DSB,
    input  logic             DSL,
    input  logic             ROT,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             SOR,
    output logic             SOL,
    output logic [CW-1:0]    CNT,
    output logic             FULL
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    mode_e            mode;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             full_reg, full_next;
    logic             right_in;
    logic             left_in;

    assign mode = mode_e'(S);

    // Serial bits entering each end of the register.
`ifdef SHIFT_REG_ROTATE_EN
    assign right_in = ROT ? q_reg[WIDTH-1] : (DSA & DSB);
    assign left_in  = ROT ? q_reg[0]       : DSL;
`else
    logic unused_rot;
    assign unused_rot = ROT;
    assign right_in   = DSA & DSB;
    assign left_in    = DSL;
`endif

    // NOTE: every variable is given a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        q_next    = q_reg;
        cnt_next  = cnt_reg;
        full_next = full_reg;
        if (CE) begin
            case (mode)
                MODE_SHR: q_next = {q_reg[WIDTH-2:0], right_in};
                MODE_SHL: q_next = {left_in, q_reg[WIDTH-1:1]};
                MODE_LOAD: q_next = D;
                default:  q_next = q_reg;
            endcase

            if (mode == MODE_SHR || mode == MODE_SHL) begin
                // A shift while already full starts a new frame at 1.
                if (cnt_reg == CW'(WIDTH)) begin
                    cnt_next = CW'(1);
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
                full_next = (cnt_next == CW'(WIDTH));
            end else if (mode == MODE_LOAD) begin
                cnt_next  = '0;
                full_next = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CP) begin
        if (MR) begin
            q_reg    <= '0;
            cnt_reg  <= '0;
            full_reg <= 1'b0;
        end else begin
            q_reg    <= q_next;
            cnt_reg  <= cnt_next;
            full_reg <= full_next;
        end
    end

    assign Q    = q_reg;
    assign SOR  = q_reg[WIDTH-1];
    assign SOL  = q_reg[0];
    assign CNT  = cnt_reg;
    assign FULL = full_reg;

endmodule

// File: tb/tb_shift_register_universal.sv
// ---------------------------------------------------------------------------
// tb_shift_register_universal
//
// Directed-vector bench for shift_register_universal (WIDTH=8). Each stimulus
// step drives inputs for one edge and pushes the hand-computed register state
// expected after that edge into a scoreboard queue; an independent monitor
// pops entries on the falling edge and compares Q, CNT, FULL, SOR and SOL.
// ---------------------------------------------------------------------------
module tb_shift_register_universal;

    localparam int WIDTH = 8;
    localparam int CW    = 4;

    logic             CP;
    logic             MR;
    logic             CE;
    logic [1:0]       S;
    logic             DSA;
    logic             DSB;
    logic             DSL;
    logic             ROT;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             SOR;
    logic             SOL;
    logic [CW-1:0]    CNT;
    logic             FULL;

    shift_register_universal #(.WIDTH(WIDTH)) dut (
        .CP   (CP),
        .MR   (MR),
        .CE   (CE),
        .S    (S),
        .DSA  (DSA),
        .DSB  (DSB),
        .DSL  (DSL),
        .ROT  (ROT),
        .D    (D),
        .Q    (Q),
        .SOR  (SOR),
        .SOL  (SOL),
        .CNT  (CNT),
        .FULL (FULL)
    );

    typedef struct {
        int               step;
        logic [WIDTH-1:0] q;
        logic [CW-1:0]    cnt;
        logic             full;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;

    initial CP = 1'b0;
    always #5 CP = ~CP;

    task automatic check(input string name, input int step,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0h expected=%0h", name, step, act, exp);
        end
    endtask

    // Monitor: compares the DUT against the oldest outstanding expectation.
    always @(negedge CP) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("q",    e.step, 32'(Q),    32'(e.q));
            check("cnt",  e.step, 32'(CNT),  32'(e.cnt));
            check("full", e.step, 32'(FULL), 32'(e.full));
            check("sor",  e.step, 32'(SOR),  32'(e.q[WIDTH-1]));
            check("sol",  e.step, 32'(SOL),  32'(e.q[0]));
        end
    end

    // One clock edge of stimulus plus the state expected after it.
    task automatic step(input logic mr, input logic ce, input logic [1:0] s,
                        input logic dsa, input logic dsb, input logic dsl,
                        input logic rot, input logic [7:0] d,
                        input logic [7:0] eq, input logic [3:0] ec, input logic ef);
        exp_t e;
        MR  = mr;
        CE  = ce;
        S   = s;
        DSA = dsa;
        DSB = dsb;
        DSL = dsl;
        ROT = rot;
        D   = d;
        @(posedge CP);
        #1;
        step_no++;
        e.step = step_no;
        e.q    = eq;
        e.cnt  = ec;
        e.full = ef;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog step=%0d actual=timeout expected=finish", step_no);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rot_exp [8];
        int         waitn;

        MR = 1'b1; CE = 1'b1; S = 2'b11; DSA = 1'b0; DSB = 1'b0;
        DSL = 1'b0; ROT = 1'b0; D = 8'hFF;

`ifdef SHIFT_REG_ROTATE_EN
        rot_exp = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
`else
        rot_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00};
`endif

        // 1. Reset suppresses a simultaneous load.
        //    mr ce s      dsa  dsb  dsl  rot  d       q      cnt ful
        step(1, 1, 2'b11, 0, 0, 0, 0, 8'hFF, 8'h00, 4'd0, 0);
        step(1, 1, 2'b11, 0, 0, 0, 0, 8'hFF, 8'h00, 4'd0, 0);

        // 2. SIPO fill: FULL on the 8th shift, then wrap and gating.
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 2'b01, 1, 1, 0, 0, 8'h00, 8'((1 << i) - 1), 4'(i), i == 8);
        end
        step(0, 1, 2'b01, 0, 1, 0, 0, 8'h00, 8'hFE, 4'd1, 0);
        step(0, 1, 2'b01, 1, 0, 0, 0, 8'h00, 8'hFC, 4'd2, 0);

        // 3. Load then left shift: SOL goes 0,1,0.
        step(0, 1, 2'b11, 0, 0, 0, 0, 8'hA5, 8'hA5, 4'd0, 0);
        step(0, 1, 2'b10, 0, 0, 0, 0, 8'h00, 8'h52, 4'd1, 0);
        step(0, 1, 2'b10, 0, 0, 0, 0, 8'h00, 8'h29, 4'd2, 0);
        step(0, 1, 2'b10, 0, 0, 0, 0, 8'h00, 8'h14, 4'd3, 0);
        step(0, 1, 2'b10, 0, 0, 1, 0, 8'h00, 8'h8A, 4'd4, 0);
        // direction change keeps counting
        step(0, 1, 2'b01, 1, 1, 0, 0, 8'h00, 8'h15, 4'd5, 0);

        // 4. Enable and hold with Q=3C, CNT=1.
        step(0, 1, 2'b11, 0, 0, 0, 0, 8'h1E, 8'h1E, 4'd0, 0);
        step(0, 1, 2'b01, 0, 0, 0, 0, 8'h00, 8'h3C, 4'd1, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 2'b01, 1, 1, 1, 0, 8'h00, 8'h3C, 4'd1, 0);
        end
        step(0, 0, 2'b11, 0, 0, 0, 0, 8'h00, 8'h3C, 4'd1, 0);
        step(0, 1, 2'b00, 1, 1, 1, 0, 8'hFF, 8'h3C, 4'd1, 0);
        step(0, 1, 2'b00, 1, 1, 1, 0, 8'hFF, 8'h3C, 4'd1, 0);
        // reset overrides a low clock enable
        step(1, 0, 2'b01, 1, 1, 0, 0, 8'h00, 8'h00, 4'd0, 0);

        // 5. Reset mid-frame.
        for (int i = 1; i <= 5; i++) begin
            step(0, 1, 2'b01, 1, 1, 0, 0, 8'h00, 8'((1 << i) - 1), 4'(i), 0);
        end
        step(1, 1, 2'b01, 1, 1, 0, 0, 8'h00, 8'h00, 4'd0, 0);

        // 6. Rotate request with serial inputs held low.
        step(0, 1, 2'b11, 0, 0, 0, 0, 8'h81, 8'h81, 4'd0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 2'b01, 0, 0, 0, 1, 8'h00, rot_exp[i], 4'(i + 1), i == 7);
        end
        // FULL falls on a load
        step(0, 1, 2'b11, 0, 0, 0, 0, 8'h81, 8'h81, 4'd0, 0);
`ifdef SHIFT_REG_ROTATE_EN
        step(0, 1, 2'b10, 0, 0, 0, 1, 8'h00, 8'hC0, 4'd1, 0);
`else
        step(0, 1, 2'b10, 0, 0, 0, 1, 8'h00, 8'h40, 4'd1, 0);
`endif

        waitn = 0;
        while (sb.size() != 0 && waitn < 10) begin
            @(negedge CP);
            waitn++;
        end
        #1;
        check("drain", step_no, 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
